// File: rtl/io_mailbox.sv
// Host side of the register-file mailbox: debounced button to timed trigger level,
// and a FIFO that streams every change of a0 to a valid/ready sink.
module io_mailbox #(
    parameter int D_WIDTH         = 32,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TRIG_CYCLES     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_async,
    input  logic [D_WIDTH-1:0]       a0,
    output logic                     trigger,
    output logic [D_WIDTH-1:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(TRIG_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TRIG_LOAD = TW'(TRIG_CYCLES);
    localparam logic [TW-1:0] TRIG_ONE  = TW'(1);
    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FIRE     = 2'd1;
    localparam logic [1:0] S_WAIT_REL = 2'd2;

    logic              r_sync1;
    logic              r_sync2;
    logic [CW-1:0]     r_db_cnt;
    logic              r_db_level;
    logic              r_db_prev;
    logic              w_db_rise;

    logic [1:0]        r_state;
    logic [TW-1:0]     r_trig_cnt;
    logic              r_trigger;

    logic [D_WIDTH-1:0] r_shadow;
    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic               r_overflow;
    logic [AW:0]        w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;

    // Two-flop synchroniser feeding a stability counter; a new level is accepted
    // only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_sync1   <= btn_async;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end
    end

    assign w_db_rise = r_db_level & ~r_db_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_trig_cnt <= '0;
            r_trigger  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_db_rise) begin
                        r_state    <= S_FIRE;
                        r_trig_cnt <= TRIG_LOAD;
                        r_trigger  <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (r_trig_cnt == TRIG_ONE) begin
                        r_state    <= S_WAIT_REL;
                        r_trig_cnt <= '0;
                        r_trigger  <= 1'b0;
                    end else begin
                        r_trig_cnt <= r_trig_cnt - TW'(1);
                    end
                end
                S_WAIT_REL: begin
                    if (!r_db_level) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_trig_cnt <= '0;
                    r_trigger  <= 1'b0;
                end
            endcase
        end
    end

    // Pointer MSB separates full from empty; a pop frees a slot for a same-cycle push.
    assign w_level    = r_wptr - r_rptr;
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (w_level == FULL_LVL);
    assign w_push_req = (a0 != r_shadow);
    assign w_pop      = ~w_empty & out_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow   <= a0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_shadow <= a0;
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= a0;
        end
    end

    assign trigger   = r_trigger;
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign overflow  = r_overflow;
    assign level     = w_level;

endmodule

// File: tb/tb_io_mailbox.sv
// Bench for io_mailbox: constant vector table, hand-timed button sequences and a
// queue-based reference model of the a0 change stream under random traffic.
module tb_io_mailbox;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int DB    = 16;
    localparam int TC    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_async = 1'b0;
    logic [DW-1:0] a0 = '0;
    logic          out_ready = 1'b0;
    logic          trigger;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          overflow;
    logic [LW-1:0] level;

    io_mailbox #(
        .D_WIDTH(DW), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB), .TRIG_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_async(btn_async), .a0(a0),
        .trigger(trigger), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the stream is just a bounded queue of a0 values that changed.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    logic [DW-1:0] m_prev = '0;

    typedef struct {
        logic [DW-1:0] a0;
        logic          rdy;
        int            lvl;
        logic          vld;
        logic [DW-1:0] data;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [DW-1:0] pre_data;
        logic          pre_hold;
        int            sz;
        bit            pop;
        pre_hold = out_valid && !out_ready && rst_n;
        pre_data = out_data;
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = a0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (a0 !== m_prev) begin
                if (sz < DEPTH || pop) mq.push_back(a0);
                else m_ovf = 1'b1;
            end
            m_prev = a0;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            chk("model_level", 64'(level), 64'(mq.size()));
            chk("model_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("model_data", 64'(out_data), (mq.size() != 0) ? 64'(mq[0]) : 64'(0));
            chk("model_ovf", 64'(overflow), 64'(m_ovf));
            if (pre_hold) chk("hold_stable", 64'(out_data), 64'(pre_data));
        end
    endtask

    task automatic do_reset(input logic [DW-1:0] a0_val);
        rst_n = 1'b0;
        a0    = a0_val;
        tick();
        tick();
        chk("rst_trigger", 64'(trigger), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        rst_n = 1'b1;
    endtask

    task automatic press_pulse(input string tag);
        int rise;
        int hi;
        int extra;
        btn_async = 1'b1;
        rise = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (trigger) begin
                rise = k;
                break;
            end
        end
        chk({tag, "_rise_cycle"}, 64'(rise), 64'(2 + DB + 1));
        hi = (rise != 0) ? 1 : 0;
        for (int k = 0; k < 20 && rise != 0; k++) begin
            tick();
            if (trigger) hi++;
            else break;
        end
        chk({tag, "_pulse_len"}, 64'(hi), 64'(TC));
        extra = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (trigger) extra++;
        end
        chk({tag, "_held_extra"}, 64'(extra), 64'(0));
        btn_async = 1'b0;
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (trigger) extra++;
        end
        chk({tag, "_release_quiet"}, 64'(extra), 64'(0));
    endtask

    initial begin
        int bounce_hits;

        tbl[0] = '{32'h1, 1'b1, 1, 1'b1, 32'h1};
        tbl[1] = '{32'h2, 1'b1, 1, 1'b1, 32'h2};
        tbl[2] = '{32'h3, 1'b1, 1, 1'b1, 32'h3};
        tbl[3] = '{32'h3, 1'b1, 0, 1'b0, 32'h0};

        // Reset with button pressed and a non-zero a0
        btn_async = 1'b1;
        out_ready = 1'b0;
        do_reset(32'h5);
        btn_async = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("post_rst_no_push", 64'(level), 64'(0));

        // Streaming through the vector table
        for (int i = 0; i < 4; i++) begin
            a0        = tbl[i].a0;
            out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].vld));
            chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(tbl[i].data));
        end

        // Debounced presses: one pulse per press, second press fires again
        press_pulse("press1");
        press_pulse("press2");

        // Bounce rejection
        bounce_hits = 0;
        for (int k = 0; k < 60; k++) begin
            btn_async = ((k / 5) % 2 == 0);
            tick();
            if (trigger) bounce_hits++;
        end
        btn_async = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (trigger) bounce_hits++;
        end
        chk("bounce_no_trigger", 64'(bounce_hits), 64'(0));

        // Overflow: nine changes into eight slots with the sink stalled
        out_ready = 1'b0;
        do_reset(32'h0);
        tick();
        for (int i = 0; i < 9; i++) begin
            a0 = 32'h100 + DW'(i);
            tick();
        end
        chk("ovf_level_full", 64'(level), 64'(DEPTH));
        chk("ovf_flag", 64'(overflow), 64'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_data", i), 64'(out_data), 64'(32'h100 + i));
            tick();
        end
        chk("drain_empty", 64'(out_valid), 64'(0));
        chk("drain_ovf_sticky", 64'(overflow), 64'(1));

        // Back-pressure at full across the pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a0 = 32'h200 + DW'(i);
            tick();
        end
        chk("wrap_full", 64'(level), 64'(DEPTH));
        for (int i = 0; i < 20; i++) begin
            a0        = 32'h300 + DW'(i);
            out_ready = i[0];
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("wrap_drained", 64'(out_valid), 64'(0));

        // Random traffic against the queue model, with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            a0        = DW'($urandom_range(0, 3));
            out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            if (i == 250) begin
                rst_n = 1'b0;
                tick();
                chk("midrst_level", 64'(level), 64'(0));
                chk("midrst_valid", 64'(out_valid), 64'(0));
                chk("midrst_ovf", 64'(overflow), 64'(0));
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
